// File: rtl/dcache_refill_pkg.sv
// Shared widths and FSM encoding for the dcache miss/refill controller.
package dcache_refill_pkg;

  localparam int unsigned DCACHE_TAG_WIDTH  = 20;
  localparam int unsigned DCACHE_IDX_WIDTH  = 8;
  localparam int unsigned DCACHE_DATA_WIDTH = 256;
  localparam int unsigned DCACHE_BUS_WIDTH  = 64;
  localparam int unsigned DCACHE_OFF_WIDTH  = 5;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StReq   = 3'd1,
    StRecv  = 3'd2,
    StFill  = 3'd3,
    StDone  = 3'd4,
    StDrain = 3'd5
  } refill_state_e;

endpackage

// File: rtl/dcache_refill_linebuf.sv
// Line assembly buffer: collects bus beats into a full cache line and tracks the beat count.
module dcache_refill_linebuf #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned BUS_W  = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              wr_i,
  input  logic [BUS_W-1:0]  dat_i,
  output logic [LINE_W-1:0] line_o,
  output logic              last_o
);

  localparam int unsigned BEATS = LINE_W / BUS_W;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [LINE_W-1:0] line_d, line_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;

  always_comb begin
    line_d = line_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      line_d = '0;
      cnt_d  = '0;
    end else if (wr_i) begin
      line_d[cnt_q*BUS_W +: BUS_W] = dat_i;
      // Wraps to 0 after the last beat so the next line starts clean.
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      line_q <= '0;
      cnt_q  <= '0;
    end else begin
      line_q <= line_d;
      cnt_q  <= cnt_d;
    end
  end

  assign line_o = line_q;
  assign last_o = (cnt_q == CNT_W'(BEATS - 1));

endmodule

// File: rtl/dcache_refill.sv
// Single-outstanding load-miss refill engine: bus line read, beat assembly, array fill, LSU done.
module dcache_refill
  import dcache_refill_pkg::*;
#(
  parameter int unsigned TAG_W  = DCACHE_TAG_WIDTH,
  parameter int unsigned IDX_W  = DCACHE_IDX_WIDTH,
  parameter int unsigned LINE_W = DCACHE_DATA_WIDTH,
  parameter int unsigned BUS_W  = DCACHE_BUS_WIDTH,
  parameter int unsigned OFF_W  = DCACHE_OFF_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_miss_vld,
  output logic                     o_miss_rdy,
  input  logic [TAG_W-1:0]         i_miss_tag,
  input  logic [IDX_W-1:0]         i_miss_idx,
  input  logic                     i_flush,
  output logic                     o_mem_req_vld,
  input  logic                     i_mem_req_rdy,
  output logic [TAG_W+IDX_W+OFF_W-1:0] o_mem_req_addr,
  input  logic                     i_mem_rsp_vld,
  input  logic [BUS_W-1:0]         i_mem_rsp_dat,
  input  logic                     i_mem_rsp_err,
  output logic                     o_dcache_wren,
  output logic [IDX_W-1:0]         o_dcache_widx,
  output logic [TAG_W-1:0]         o_dcache_wtag,
  output logic [LINE_W-1:0]        o_dcache_wdat,
  output logic                     o_done_vld,
  output logic                     o_done_err
);

  refill_state_e    state_d, state_q;
  logic [TAG_W-1:0] tag_d, tag_q;
  logic [IDX_W-1:0] idx_d, idx_q;
  logic             err_d, err_q;
  logic             lb_clr, lb_wr, lb_last;

  dcache_refill_linebuf #(
    .LINE_W(LINE_W),
    .BUS_W (BUS_W)
  ) u_linebuf (
    .clk_i (clk),
    .rst_ni(rst_n),
    .clr_i (lb_clr),
    .wr_i  (lb_wr),
    .dat_i (i_mem_rsp_dat),
    .line_o(o_dcache_wdat),
    .last_o(lb_last)
  );

  always_comb begin
    state_d       = state_q;
    tag_d         = tag_q;
    idx_d         = idx_q;
    err_d         = err_q;
    lb_clr        = 1'b0;
    lb_wr         = 1'b0;
    o_miss_rdy    = 1'b0;
    o_mem_req_vld = 1'b0;
    o_dcache_wren = 1'b0;
    o_done_vld    = 1'b0;

    unique case (state_q)
      StIdle: begin
        o_miss_rdy = 1'b1;
        if (i_miss_vld) begin
          tag_d   = i_miss_tag;
          idx_d   = i_miss_idx;
          err_d   = 1'b0;
          lb_clr  = 1'b1;
          state_d = StReq;
        end
      end
      StReq: begin
        o_mem_req_vld = 1'b1;
        // A flush racing the accept still leaves beats in flight, so they must be drained.
        if (i_mem_req_rdy) begin
          state_d = i_flush ? StDrain : StRecv;
        end else if (i_flush) begin
          state_d = StIdle;
        end
      end
      StRecv: begin
        if (i_mem_rsp_vld) begin
          lb_wr = 1'b1;
          err_d = err_q | i_mem_rsp_err;
          if (lb_last) begin
            state_d = i_flush ? StIdle : (err_d ? StDone : StFill);
          end else if (i_flush) begin
            state_d = StDrain;
          end
        end else if (i_flush) begin
          state_d = StDrain;
        end
      end
      StFill: begin
        o_dcache_wren = 1'b1;
        state_d       = StDone;
      end
      StDone: begin
        o_done_vld = 1'b1;
        state_d    = StIdle;
      end
      StDrain: begin
        if (i_mem_rsp_vld) begin
          lb_wr = 1'b1;
          if (lb_last) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      tag_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  assign o_mem_req_addr = {tag_q, idx_q, {OFF_W{1'b0}}};
  assign o_dcache_widx  = idx_q;
  assign o_dcache_wtag  = tag_q;
  assign o_done_err     = o_done_vld & err_q;

endmodule
